// File: rtl/ram_burst_master_if.sv
// Signal bundle between a burst initiator, its command/data source and the single-port RAM.
// master: burst-master side (drives RAM pins, read stream, status, wdata_ready).
// slave : environment side (drives commands, write stream, RAM read data).
interface ram_burst_master_if #(
   parameter int AW = 8,
   parameter int DW = 64
);
   logic          m_req;
   logic          m_wr;
   logic [AW-1:0] m_addr;
   logic [AW-1:0] m_len;
   logic [DW-1:0] wdata;
   logic          wdata_valid;
   logic          wdata_ready;
   logic [DW-1:0] rdata;
   logic          rdata_valid;
   logic          busy;
   logic          done;
   logic          cen;
   logic          wen;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_din;
   logic [DW-1:0] s_dout;

   modport master (
      input  m_req, m_wr, m_addr, m_len, wdata, wdata_valid, s_dout,
      output wdata_ready, rdata, rdata_valid, busy, done, cen, wen, s_addr, s_din
   );

   modport slave (
      output m_req, m_wr, m_addr, m_len, wdata, wdata_valid, s_dout,
      input  wdata_ready, rdata, rdata_valid, busy, done, cen, wen, s_addr, s_din
   );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port sync RAM: one command -> len+1 consecutive-address reads or writes.
// Latency: read data strobes 3 edges after command accept, one word per cycle; done 1 cycle after last access.
// Backpressure: write stream throttled by wdata_valid (bubbles leave cen low); read stream has none.
// Ports: clk, reset_n (async, active low); bus carries command (m_*), write stream (wdata*),
//        read stream (rdata*), status (busy, done) and RAM pins (cen, wen, s_addr, s_din, s_dout).
// Every output is a flop; nothing on the bus reaches an output without passing a register.
module ram_burst_master #(
   parameter int AW = 8,
   parameter int DW = 64
) (
   input logic             clk,
   input logic             reset_n,
   ram_burst_master_if.master bus
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] cnt_q, cnt_d;          // words remaining minus one
   logic          rd_pend_q, rd_pend_d;  // RAM is producing read data this cycle
   logic          cen_q, cen_d;
   logic          wen_q, wen_d;
   logic [AW-1:0] s_addr_q, s_addr_d;
   logic [DW-1:0] s_din_q, s_din_d;
   logic          wdata_ready_q, wdata_ready_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          rdata_valid_q, rdata_valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         cnt_q         <= '0;
         rd_pend_q     <= 1'b0;
         cen_q         <= 1'b0;
         wen_q         <= 1'b0;
         s_addr_q      <= '0;
         s_din_q       <= '0;
         wdata_ready_q <= 1'b0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         rd_pend_q     <= rd_pend_d;
         cen_q         <= cen_d;
         wen_q         <= wen_d;
         s_addr_q      <= s_addr_d;
         s_din_q       <= s_din_d;
         wdata_ready_q <= wdata_ready_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      cen_d         = 1'b0;              // RAM idles unless an issue is made this edge
      wen_d         = 1'b0;
      s_addr_d      = s_addr_q;
      s_din_d       = s_din_q;
      wdata_ready_d = wdata_ready_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      // Read pipeline: issue registered -> RAM samples next edge -> capture one edge later.
      rd_pend_d     = cen_q & ~wen_q;
      rdata_valid_d = rd_pend_q;
      rdata_d       = rd_pend_q ? bus.s_dout : rdata_q;

      unique case (state_q)
         IDLE: begin
            if (bus.m_req) begin
               ptr_d         = bus.m_addr;
               cnt_d         = bus.m_len;
               busy_d        = 1'b1;
               wdata_ready_d = bus.m_wr;
               state_d       = bus.m_wr ? WRITE : READ;
            end
         end
         WRITE: begin
            if (bus.wdata_valid) begin
               cen_d    = 1'b1;
               wen_d    = 1'b1;
               s_addr_d = ptr_q;
               s_din_d  = bus.wdata;
               ptr_d    = ptr_q + AW'(1);
               cnt_d    = cnt_q - AW'(1);
               if (cnt_q == '0) begin
                  wdata_ready_d = 1'b0;
                  state_d       = FINISH;
               end
            end
         end
         READ: begin
            cen_d    = 1'b1;
            s_addr_d = ptr_q;
            ptr_d    = ptr_q + AW'(1);
            cnt_d    = cnt_q - AW'(1);
            if (cnt_q == '0) state_d = DRAIN;
         end
         DRAIN: begin
            // The last word is being captured once its issue has left cen and it is pending.
            if (rd_pend_q && !cen_q) state_d = FINISH;
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.cen         = cen_q;
   assign bus.wen         = wen_q;
   assign bus.s_addr      = s_addr_q;
   assign bus.s_din       = s_din_q;
   assign bus.wdata_ready = wdata_ready_q;
   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = rdata_valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: directed bursts against a behavioural sync RAM,
// with expected RAM writes and read words queued at command time and checked as they appear.
module tb_ram_burst_master;
   localparam int AW = 8;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   ram_burst_master_if #(.AW(AW), .DW(DW)) bus ();
   ram_burst_master #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW-1:0] model [256];
   logic [DW-1:0] rq [$];
   logic [AW-1:0] wq_addr [$];
   logic [DW-1:0] wq_dat [$];

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {32'hC0DE_F00D, 24'h0, a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
   endtask

   // Behavioural single-port RAM: registered read data.
   logic [DW-1:0] ram [256];
   bit            ram_vld [256];
   always @(posedge clk) begin
      if (bus.cen) begin
         if (bus.wen) begin
            ram[bus.s_addr]     <= bus.s_din;
            ram_vld[bus.s_addr] <= 1'b1;
         end else begin
            bus.s_dout <= ram_vld[bus.s_addr] ? ram[bus.s_addr] : pat(bus.s_addr);
         end
      end
   end

   // Output monitor: pops scoreboard entries as the DUT produces RAM writes and read words.
   always @(negedge clk) begin
      logic [DW-1:0] ed;
      logic [AW-1:0] ea;
      if (bus.rdata_valid) begin
         if (rq.size() == 0) chk("rd_unexpected", 1, 0);
         else begin
            ed = rq.pop_front();
            chk("rdata", bus.rdata, ed);
         end
      end
      if (bus.cen && bus.wen) begin
         if (wq_addr.size() == 0) chk("wr_unexpected", 1, 0);
         else begin
            ea = wq_addr.pop_front();
            ed = wq_dat.pop_front();
            chk("wr_addr", bus.s_addr, ea);
            chk("wr_data", bus.s_din, ed);
         end
      end
      chk("wen_needs_cen", bus.wen & ~bus.cen, 0);
   end

   task automatic burst(input string tag, input bit wr, input logic [7:0] addr, input logic [7:0] len,
                        input int gap_after, input int gap_len, input int poke_at, input int exp_first,
                        input logic [31:0] dseed);
      int nw, sent, gap_left, cyc, first_rv, ndone, done_cyc, busy_low, n_iss, first_iss, last_iss;
      bit gap_prev, busy_at_done;
      logic [7:0]    a;
      logic [DW-1:0] d;
      nw = int'(len) + 1;
      for (int i = 0; i < nw; i++) begin
         a = addr + 8'(i);
         if (wr) begin
            d = {dseed, 32'(i) + 32'd1};
            model[a] = d;
            wq_addr.push_back(a);
            wq_dat.push_back(d);
         end else begin
            rq.push_back(model[a]);
         end
      end
      @(negedge clk);
      bus.m_req = 1'b1; bus.m_wr = wr; bus.m_addr = addr; bus.m_len = len;
      sent = 0; gap_left = (gap_after >= 0) ? gap_len : 0; gap_prev = 1'b0;
      cyc = 0; first_rv = -1; ndone = 0; done_cyc = 0; busy_low = 0; busy_at_done = 1'b1;
      n_iss = 0; first_iss = 0; last_iss = 0;
      while (ndone == 0 && cyc < 2 * nw + gap_len + 20) begin
         @(negedge clk);
         cyc++;
         bus.m_req = (cyc == poke_at);
         if (gap_prev) begin
            chk({tag, "_gap_cen"}, bus.cen, 0);
            gap_prev = 1'b0;
         end
         if (bus.rdata_valid && first_rv < 0) first_rv = cyc - 1;
         if (bus.cen && (bus.wen == wr)) begin
            if (n_iss == 0) first_iss = cyc;
            last_iss = cyc;
            n_iss++;
         end
         if (bus.done) begin
            ndone++;
            done_cyc = cyc;
            busy_at_done = bus.busy;
         end else if (!bus.busy) busy_low++;
         if (wr) begin
            if (bus.wdata_ready && sent < nw) begin
               if (sent == gap_after && gap_left > 0) begin
                  bus.wdata_valid = 1'b0;
                  gap_left--;
                  gap_prev = 1'b1;
               end else begin
                  bus.wdata = {dseed, 32'(sent) + 32'd1};
                  bus.wdata_valid = 1'b1;
                  sent++;
               end
            end else bus.wdata_valid = 1'b0;
         end
      end
      bus.m_req = 1'b0;
      bus.wdata_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk({tag, "_done_count"}, ndone, 1);
      chk({tag, "_busy_held"}, busy_low, 0);
      chk({tag, "_busy_at_done"}, busy_at_done, 0);
      chk({tag, "_n_issue"}, n_iss, nw);
      chk({tag, "_issue_span"}, last_iss - first_iss, nw - 1 + ((gap_after >= 0) ? gap_len : 0));
      if (wr) begin
         chk({tag, "_done_after_last"}, done_cyc - last_iss, 1);
         chk({tag, "_wq_empty"}, wq_addr.size(), 0);
      end else begin
         chk({tag, "_first_rv"}, first_rv, exp_first);
         chk({tag, "_rq_empty"}, rq.size(), 0);
      end
   endtask

   initial begin
      int niss, cyc, ndone;
      logic [7:0] a;
      for (int i = 0; i < 256; i++) model[i] = pat(8'(i));
      bus.m_req = 1'b1; bus.m_wr = 1'b0; bus.m_addr = '0; bus.m_len = '0;
      bus.wdata = '0; bus.wdata_valid = 1'b0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;

      // Held in reset with m_req asserted.
      repeat (3) @(negedge clk);
      chk("rst_cen", bus.cen, 0);
      chk("rst_wen", bus.wen, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_rvalid", bus.rdata_valid, 0);
      chk("rst_wready", bus.wdata_ready, 0);
      chk("rst_saddr", bus.s_addr, 0);
      chk("rst_sdin", bus.s_din, 0);
      chk("rst_rdata", bus.rdata, 0);
      reset_n = 1'b1;
      bus.m_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_cen", bus.cen, 0);
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_rvalid", bus.rdata_valid, 0);
      chk("post_rst_wready", bus.wdata_ready, 0);

      burst("wr1",     1'b1, 8'h10, 8'd3, -1, 0, 0, 3, 32'h0);
      burst("rd1",     1'b0, 8'h10, 8'd3, -1, 0, 0, 3, 32'h0);
      burst("wr_gap",  1'b1, 8'h10, 8'd3,  2, 2, 0, 3, 32'h1);
      burst("rd_gap",  1'b0, 8'h10, 8'd3, -1, 0, 0, 3, 32'h0);
      burst("wr_wrap", 1'b1, 8'hFE, 8'd2, -1, 0, 0, 3, 32'h2);
      burst("rd_wrap", 1'b0, 8'hFE, 8'd2, -1, 0, 0, 3, 32'h0);
      burst("rd_full", 1'b0, 8'h00, 8'hFF, -1, 0, 50, 3, 32'h0);

      // Reset during word 5 of an 8-word read.
      for (int i = 0; i < 8; i++) begin
         a = 8'h40 + 8'(i);
         rq.push_back(model[a]);
      end
      @(negedge clk);
      bus.m_req = 1'b1; bus.m_wr = 1'b0; bus.m_addr = 8'h40; bus.m_len = 8'd7;
      niss = 0; cyc = 0;
      while (niss < 5 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         bus.m_req = 1'b0;
         if (bus.cen && !bus.wen) niss++;
      end
      chk("rst_mid_reached", niss, 5);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_cen", bus.cen, 0);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_rvalid", bus.rdata_valid, 0);
      rq.delete();
      ndone = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("rst_mid_no_done", ndone, 0);
      chk("rst_mid_idle_cen", bus.cen, 0);

      burst("rd_after_rst", 1'b0, 8'h20, 8'd0, -1, 0, 0, 3, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
